// File: rtl/debug_uart_tx_if.sv
// rtl/debug_uart_tx_if.sv - request/serial-line bundle between the debug slave and debug_uart_tx
//
// Purpose: groups the send request, the word to send and the UART-side status
//          signals so the transmitter and its requester share one port.
// Signals:
//   tx_flag      requester -> tx : send request, rising edge is a request
//   data_in[31:0] requester -> tx : word to transmit, sampled on acceptance
//   tx           tx -> requester : UART serial line, idle high
//   busy         tx -> requester : word in flight
//   doneSending  tx -> requester : one-cycle completion pulse
//   byte_idx[1:0] tx -> requester : byte currently on the line
interface debug_uart_tx_if;
  logic        tx_flag;
  logic [31:0] data_in;
  logic        tx;
  logic        busy;
  logic        doneSending;
  logic [1:0]  byte_idx;

  modport master (
    output tx_flag, data_in,
    input  tx, busy, doneSending, byte_idx
  );

  modport slave (
    input  tx_flag, data_in,
    output tx, busy, doneSending, byte_idx
  );
endinterface

// File: rtl/debug_uart_tx.sv
// rtl/debug_uart_tx.sv - 8N1 UART transmitter for 32-bit debug readback words
//
// Purpose: on each rising edge of bus.tx_flag seen while idle, sends NBYTES bytes
//          of bus.data_in LSB-byte first, each as start + 8 data (LSB first) +
//          stop, with no gap between bytes, then pulses bus.doneSending.
// Ports:
//   CLK  system clock, rising edge
//   RST  synchronous active-high reset
//   bus  debug_uart_tx_if.slave (tx_flag, data_in in; tx, busy, doneSending, byte_idx out)
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   NBYTES        bytes per request (1..4)
module debug_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NBYTES       = 4
) (
  input  logic           CLK,
  input  logic           RST,
  debug_uart_tx_if.slave bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]        BYTE_LAST = 2'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              flag_q;
  logic [31:0]       word_q, word_d;
  logic [7:0]        shift_q, shift_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic req;
  logic baud_tc;

  assign req     = bus.tx_flag & ~flag_q;
  assign baud_tc = (baud_q == BAUD_LAST);

  // All outputs are registered: each state computes the line level for the
  // next cycle, so a transition and its new tx level appear together.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    byte_idx_d = byte_idx_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    baud_d     = baud_tc ? '0 : baud_q + BAUD_W'(1);

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (req) begin
          word_d     = bus.data_in;
          shift_d    = bus.data_in[7:0];
          byte_idx_d = 2'd0;
          bit_d      = 3'd0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_START;
        end
      end

      S_START: begin
        if (baud_tc) begin
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_tc) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end

      S_STOP: begin
        if (baud_tc) begin
          if (byte_idx_q != BYTE_LAST) begin
            // The word register shifts down a byte per byte sent, so the
            // next byte is always found in bits 15:8.
            byte_idx_d = byte_idx_q + 2'd1;
            word_d     = {8'h00, word_q[31:8]};
            shift_d    = word_q[15:8];
            tx_d       = 1'b0;
            state_d    = S_START;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // One cycle only; a request edge here is consumed by flag_q and lost.
        baud_d  = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      flag_q     <= 1'b0;
      word_q     <= '0;
      shift_q    <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_idx_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      flag_q     <= bus.tx_flag;
      word_q     <= word_d;
      shift_q    <= shift_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_idx_q <= byte_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.tx          = tx_q;
  assign bus.busy        = busy_q;
  assign bus.doneSending = done_q;
  assign bus.byte_idx    = byte_idx_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
// tb/tb_debug_uart_tx.sv - directed self-checking bench for debug_uart_tx
//
// Purpose: drives two transmitters (NBYTES=4 and NBYTES=1, both 4 clocks/bit)
//          with directed requests and checks line waveform, decoded bytes,
//          busy/doneSending/byte_idx timing against a bit-level frame model.
// Ports: none.
module tb_debug_uart_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debug_uart_tx_if ifa ();
  debug_uart_tx_if ifb ();

  debug_uart_tx #(.CLKS_PER_BIT(4), .NBYTES(4)) dut_a (.CLK(clk), .RST(rst), .bus(ifa));
  debug_uart_tx #(.CLKS_PER_BIT(4), .NBYTES(1)) dut_b (.CLK(clk), .RST(rst), .bus(ifb));

  int n_tests = 0;
  int n_fail  = 0;

  // Selects which transmitter the frame-watching task drives and observes.
  logic       sel;
  logic       tx_s, busy_s, done_s;
  logic [1:0] bidx_s;
  assign tx_s   = sel ? ifb.tx          : ifa.tx;
  assign busy_s = sel ? ifb.busy        : ifa.busy;
  assign done_s = sel ? ifb.doneSending : ifa.doneSending;
  assign bidx_s = sel ? ifb.byte_idx    : ifa.byte_idx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flag(input logic v, input logic [31:0] d);
    if (sel) begin
      ifb.tx_flag = v;
      ifb.data_in = d;
    end else begin
      ifa.tx_flag = v;
      ifa.data_in = d;
    end
  endtask

  // Line level expected c cycles after the tx falling edge, 4 clocks per bit.
  function automatic logic exp_tx(input logic [31:0] w, input int c);
    int         b;
    int         p;
    logic [7:0] bv;
    b  = c / 40;
    p  = (c % 40) / 4;
    bv = 8'(w >> (8 * b));
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return bv[p-1];
  endfunction

  // Raises the request, then samples one cycle at a time: c=0 is the first
  // cycle the line should be low. Stimulus events happen at given cycles.
  task automatic watch(input logic [31:0] w, input int nb, input int drop_at,
                       input int repulse_at, input int extra,
                       output int errs, output logic [31:0] dec,
                       output int done_cnt, output int done_at, output logic first_tx);
    int frame;
    frame    = nb * 40;
    errs     = 0;
    dec      = '0;
    done_cnt = 0;
    done_at  = -1;
    set_flag(1'b1, w);
    tick();
    first_tx = tx_s;
    for (int c = 0; c < frame + 1 + extra; c++) begin
      if (c < frame) begin
        if (tx_s !== exp_tx(w, c) || busy_s !== 1'b1 || done_s !== 1'b0 ||
            bidx_s !== 2'(c / 40))
          errs++;
        if ((c % 4) == 2 && ((c % 40) / 4) >= 1 && ((c % 40) / 4) <= 8)
          dec[8 * (c / 40) + ((c % 40) / 4) - 1] = tx_s;
      end else if (c == frame) begin
        if (tx_s !== 1'b1 || busy_s !== 1'b0) errs++;
      end else begin
        if (tx_s !== 1'b1 || busy_s !== 1'b0 || done_s !== 1'b0) errs++;
      end
      if (done_s === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (c == drop_at)        set_flag(1'b0, ~w);
      if (c == repulse_at)     set_flag(1'b1, 32'h1234_5678);
      if (c == repulse_at + 2) set_flag(1'b0, 32'h1234_5678);
      tick();
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ifa.tx !== 1'b1 || ifa.busy !== 1'b0 || ifa.doneSending !== 1'b0 ||
          ifa.byte_idx !== 2'd0)
        bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_hold: %0d bad cycles, required 0", bad);
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ifa.tx !== 1'b1 || ifa.busy !== 1'b0 || ifa.doneSending !== 1'b0 ||
          ifa.byte_idx !== 2'd0 || ifb.tx !== 1'b1 || ifb.busy !== 1'b0)
        bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_release: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic check_frame(input string name, input int errs, input logic [31:0] dec,
                             input logic [31:0] exp_dec, input int done_cnt,
                             input int done_at, input int exp_done_at, input logic first_tx);
    n_tests++;
    if (first_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL %s latency: tx=%b one cycle after req, required 0", name, first_tx);
    end
    n_tests++;
    if (errs !== 0) begin
      n_fail++;
      $display("FAIL %s waveform: %0d bad cycles, required 0", name, errs);
    end
    n_tests++;
    if (dec !== exp_dec) begin
      n_fail++;
      $display("FAIL %s decode: got %h, required %h", name, dec, exp_dec);
    end
    n_tests++;
    if (done_cnt !== 1 || done_at !== exp_done_at) begin
      n_fail++;
      $display("FAIL %s done: %0d pulses at %0d, required 1 at %0d",
               name, done_cnt, done_at, exp_done_at);
    end
  endtask

  task automatic test_single();
    int errs, dcnt, dat;
    logic [31:0] dec;
    logic ft;
    sel = 1'b0;
    watch(32'hA55A_0F31, 4, 0, -1, 5, errs, dec, dcnt, dat, ft);
    check_frame("single", errs, dec, {8'hA5, 8'h5A, 8'h0F, 8'h31}, dcnt, dat, 160, ft);
  endtask

  task automatic test_held();
    int errs, dcnt, dat;
    logic [31:0] dec;
    logic ft;
    sel = 1'b0;
    watch(32'h0000_00FF, 4, 499, -1, 360, errs, dec, dcnt, dat, ft);
    check_frame("held", errs, dec, {8'h00, 8'h00, 8'h00, 8'hFF}, dcnt, dat, 160, ft);
  endtask

  task automatic test_busy_req();
    int errs, dcnt, dat;
    logic [31:0] dec;
    logic ft;
    sel = 1'b0;
    watch(32'hC3D2_E1F0, 4, 0, 50, 60, errs, dec, dcnt, dat, ft);
    check_frame("busy_req", errs, dec, 32'hC3D2_E1F0, dcnt, dat, 160, ft);
  endtask

  task automatic test_reset_mid();
    int errs, dcnt, dat, bad;
    logic [31:0] dec;
    logic ft;
    sel = 1'b0;
    set_flag(1'b1, 32'h5A5A_A5A5);
    tick();
    for (int c = 0; c < 70; c++) begin
      if (c == 0) set_flag(1'b0, 32'h5A5A_A5A5);
      tick();
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if (ifa.tx !== 1'b1 || ifa.busy !== 1'b0 || ifa.doneSending !== 1'b0 ||
        ifa.byte_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid: tx=%b busy=%b done=%b idx=%0d, required 1 0 0 0",
               ifa.tx, ifa.busy, ifa.doneSending, ifa.byte_idx);
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ifa.tx !== 1'b1 || ifa.busy !== 1'b0 || ifa.doneSending !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: %0d bad cycles, required 0", bad);
    end
    watch(32'h0BAD_F00D, 4, 0, -1, 5, errs, dec, dcnt, dat, ft);
    check_frame("after_reset", errs, dec, {8'h0B, 8'hAD, 8'hF0, 8'h0D}, dcnt, dat, 160, ft);
  endtask

  task automatic test_nbytes1_back_to_back();
    int errs, dcnt, dat;
    logic [31:0] dec;
    logic ft;
    sel = 1'b1;
    // 0x80 on the line: start, 0,0,0,0,0,0,0,1, stop.
    watch(32'h0000_0080, 1, 0, -1, 0, errs, dec, dcnt, dat, ft);
    check_frame("nb1", errs, dec, 32'h0000_0080, dcnt, dat, 40, ft);
    // The watch above ends on the first IDLE cycle after DONE.
    watch(32'h0000_005C, 1, 0, -1, 3, errs, dec, dcnt, dat, ft);
    check_frame("nb1_b2b", errs, dec, 32'h0000_005C, dcnt, dat, 40, ft);
  endtask

  task automatic test_done_cycle_req();
    int errs, dcnt, dat;
    logic [31:0] dec;
    logic ft;
    sel = 1'b1;
    watch(32'h0000_003C, 1, 0, 40, 12, errs, dec, dcnt, dat, ft);
    check_frame("done_req", errs, dec, 32'h0000_003C, dcnt, dat, 40, ft);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    sel         = 1'b0;
    rst         = 1'b1;
    ifa.tx_flag = 1'b0;
    ifa.data_in = '0;
    ifb.tx_flag = 1'b0;
    ifb.data_in = '0;
    test_reset();
    test_single();
    test_held();
    test_busy_req();
    test_reset_mid();
    test_nbytes1_back_to_back();
    test_done_cycle_req();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
